// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port RAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision between two requesters; round-robin when MEM_ARB_RR_EN is defined, else requester 0 wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    valid0,
    input  logic    valid1,
    input  req_id_t last_grant,
    output req_id_t grant,
    output logic    grant_valid
);

    // Pick a requester; on a tie either alternate or favour requester 0
    always_comb begin
        grant_valid = valid0 | valid1;
        grant       = 1'b0;
        if (valid0 && valid1) begin
`ifdef MEM_ARB_RR_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
        end else if (valid1) begin
            grant = 1'b1;
        end
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority ignores history
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port RAM (IDLE -> ACCESS -> RESP); tie-break set by MEM_ARB_RR_EN.
// Latency: accept at cycle N, RAM strobe at N+1, response pulse at N+2; one transaction per 3 cycles.
// Backpressure: ready is low outside IDLE and for the losing requester; waiting requests hold valid.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        state, state_nxt;
    req_id_t           grant, last_grant, cmd_id;
    logic              grant_valid, accept;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    mem_arb_pick u_pick (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and all outputs; rst gates everything so an in-flight access never reaches the RAM
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_rdata = '0;
        rsp1_rdata = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        accept     = 1'b1;
                        req0_ready = (grant == 1'b0) && req0_valid;
                        req1_ready = (grant == 1'b1) && req1_valid;
                        state_nxt  = ACCESS;
                    end
                end
                ACCESS: begin
                    ram_en    = 1'b1;
                    ram_we    = cmd_we;
                    ram_addr  = cmd_addr;
                    ram_wdata = cmd_wdata;
                    state_nxt = RESP;
                end
                RESP: begin
                    if (cmd_id == 1'b0) begin
                        rsp0_valid = 1'b1;
                        rsp0_rdata = cmd_we ? '0 : ram_rdata;
                    end else begin
                        rsp1_valid = 1'b1;
                        rsp1_rdata = cmd_we ? '0 : ram_rdata;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Capture the winning command so later input changes cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_id     <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            cmd_id     <= grant;
            cmd_we     <= grant ? req1_we    : req0_we;
            cmd_addr   <= grant ? req1_addr  : req0_addr;
            cmd_wdata  <= grant ? req1_wdata : req0_wdata;
            last_grant <= grant;
        end
    end

endmodule
